div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
//   Multi-cycle divider sequencer for the EX stage of the 5-stage MIPS32 pipeline (DIV/DIVU).
//   Accepts a divide request from ex and runs a WIDTH-step restoring division under an FSM.
//   Raises a stall request to hold the pipeline while busy.
//   Returns {remainder, quotient} for ex to forward as hiData/loData with wHiLo set.
// PARAMETERS
//   WIDTH   32  operand width in bits.
//   CNT_W   6   step counter width; must satisfy 2**CNT_W > WIDTH.
// PORTS
//   clk         in   1        system clock; single clock domain.
//   rst         in   1        reset, asynchronous, active-low (0 = reset).
//   start_i     in   1        divide request from ex; held high until ready_o is seen.
//   signed_i    in   1        1 = DIV (two's complement), 0 = DIVU; sampled with start_i.
//   opNum1_i    in   WIDTH    dividend; sampled with start_i.
//   opNum2_i    in   WIDTH    divisor; sampled with start_i.
//   annul_i     in   1        abort the current or pending operation (pipeline flush).
//   result_o    out  2*WIDTH  {remainder (hi), quotient (lo)}; registered.
//   ready_o     out  1        result_o valid; high only in state DONE.
//   stallreq_o  out  1        pipeline stall request to the stall controller.
// BEHAVIOUR
// - Reset (rst=0, asynchronous): state=IDLE, cnt=0, result_o=0, ready_o=0, working regs=0.
// - States: IDLE, DIVZERO, BUSY, DONE. All transitions occur on the rising edge of clk.
//   - IDLE: if start_i & !annul_i:
//     - If opNum2_i==0, go to DIVZERO.
//     - Otherwise go to BUSY. Latch |dividend| and |divisor| (abs only when signed_i), both sign bits, and signed_i.
//     - Set cnt=0 and clear the partial remainder.
//   - BUSY: one restoring step per edge.
//     - Shift {rem, quo} left by 1 bit.
//     - Trial-subtract the divisor from rem (WIDTH+1-bit subtract).
//     - If there is no borrow, take the difference and set quo[0]=1.
//     - Increment cnt. The step performed at cnt==WIDTH-1 moves to DONE.
//     - On that same edge, load result_o with sign fixup:
//       - Quotient negated iff signed and dividend sign != divisor sign.
//       - Remainder negated iff signed and dividend negative.
//   - DIVZERO: next edge goes to DONE with result_o = 0.
//   - DONE: ready_o=1 and result_o held. Return to IDLE on the first edge with start_i==0.
//     - If start_i stays high, remain in DONE; a new request needs start_i low for at least 1 cycle.
// - Latency, counted from the edge that samples start_i in IDLE:
//   - ready_o rises after WIDTH+1 edges (33 for WIDTH=32).
//   - Divide-by-zero: ready_o rises after 2 edges.
// - stallreq_o = start_i & !ready_o & !annul_i (combinational).
//   It is high during the IDLE cycle in which start_i arrives.
// - annul_i=1 in any state forces IDLE on the next edge. ready_o=0 after that edge; result_o is not updated.
// - annul_i takes priority over start_i and over BUSY completion when both occur on the same edge.
// - Operands changing during BUSY are ignored; only the latched values are used.
// - Signed overflow (-2**(WIDTH-1) / -1): quotient wraps to 0x80000000 and remainder is 0. No trap.
// - result_o retains its last value in IDLE. Consumers qualify it with ready_o.
// TESTING
// - DIVU 100/7: start_i=1 and held.
//   - Required: stallreq_o=1 for 33 cycles.
//   - Required: ready_o high after edge 33 with result_o = {32'd2, 32'd14}. stallreq_o drops.
// - DIV -7/2 (0xFFFFFFF9 / 0x2): result_o = {0xFFFFFFFF, 0xFFFFFFFD}.
//   Also check 7/-2, which requires {0x1, 0xFFFFFFFD}.
// - Divide by zero (opNum2_i=0): ready_o after 2 edges with result_o=0.
//   Dropping start_i then returns the FSM to IDLE on the next edge.
// - annul_i pulsed at edge 10 of BUSY: IDLE after that edge, and stallreq_o=0 in the same cycle.
//   A fresh 50/5 request then gives {0, 10}.
// - rst driven low asynchronously mid-BUSY: outputs go to 0 immediately without waiting for a clk edge.
//   After release, start_i high gives a full 33-edge operation.
// - Signed 0x80000000/0xFFFFFFFF: {0x0, 0x80000000}. Unsigned 0xFFFFFFFF/0x1: {0x0, 0xFFFFFFFF}.

Source files
------------

// File: rtl/div_seq_if.sv
// Handshake bundle between the EX stage and the multi-cycle divider sequencer.
// The EX stage drives the request side (master); the divider answers (slave).
interface div_seq_if #(
   parameter int WIDTH = 32
);
   logic               start_i;
   logic               signed_i;
   logic [WIDTH-1:0]   opNum1_i;
   logic [WIDTH-1:0]   opNum2_i;
   logic               annul_i;
   logic [2*WIDTH-1:0] result_o;
   logic               ready_o;
   logic               stallreq_o;

   modport master (
      output start_i, signed_i, opNum1_i, opNum2_i, annul_i,
      input  result_o, ready_o, stallreq_o
   );

   modport slave (
      input  start_i, signed_i, opNum1_i, opNum2_i, annul_i,
      output result_o, ready_o, stallreq_o
   );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU in the EX stage.
// Holds the pipeline through stallreq_o and returns {remainder, quotient}.
module div_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic       clk,
   input  logic       rst,
   div_seq_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DIVZERO = 2'd1,
      BUSY    = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t             state_r;
   state_t             stateNext_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [WIDTH-1:0]   rem_r;
   logic [WIDTH-1:0]   quo_r;
   logic [WIDTH-1:0]   divisor_r;
   logic               dividendSign_r;
   logic               divisorSign_r;
   logic               signed_r;
   logic [2*WIDTH-1:0] result_r;
   logic               ready_r;

   logic [WIDTH-1:0]   absDividend_s;
   logic [WIDTH-1:0]   absDivisor_s;
   logic [WIDTH:0]     remShift_s;
   logic [WIDTH:0]     trialDiff_s;
   logic               borrow_s;
   logic [WIDTH-1:0]   remStep_s;
   logic [WIDTH-1:0]   quoStep_s;
   logic [WIDTH-1:0]   quoFixed_s;
   logic [WIDTH-1:0]   remFixed_s;
   logic               lastStep_s;
   logic               divByZero_s;

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   assign divByZero_s   = (bus.opNum2_i == {WIDTH{1'b0}});
   assign absDividend_s = (bus.signed_i && bus.opNum1_i[WIDTH-1]) ? negate(bus.opNum1_i) : bus.opNum1_i;
   assign absDivisor_s  = (bus.signed_i && bus.opNum2_i[WIDTH-1]) ? negate(bus.opNum2_i) : bus.opNum2_i;

   // The partial remainder stays below the divisor, so bit WIDTH of the
   // WIDTH+1-bit difference is set exactly when the trial subtract borrows.
   assign remShift_s  = {rem_r, quo_r[WIDTH-1]};
   assign trialDiff_s = remShift_s - {1'b0, divisor_r};
   assign borrow_s    = trialDiff_s[WIDTH];
   assign remStep_s   = borrow_s ? remShift_s[WIDTH-1:0] : trialDiff_s[WIDTH-1:0];
   assign quoStep_s   = {quo_r[WIDTH-2:0], ~borrow_s};
   assign lastStep_s  = (cnt_r == CNT_W'(WIDTH-1));

   // Signed overflow falls out naturally: |min|/1 = 0x80..0 with no negation.
   assign quoFixed_s  = (signed_r && (dividendSign_r != divisorSign_r)) ? negate(quoStep_s) : quoStep_s;
   assign remFixed_s  = (signed_r && dividendSign_r) ? negate(remStep_s) : remStep_s;

   // Next-state selection; a flush overrides every other transition.
   always_comb begin
      stateNext_s = state_r;
      if (bus.annul_i) begin
         stateNext_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start_i) begin
                  stateNext_s = divByZero_s ? DIVZERO : BUSY;
               end else begin
                  stateNext_s = IDLE;
               end
            end
            BUSY: begin
               if (lastStep_s) begin
                  stateNext_s = DONE;
               end else begin
                  stateNext_s = BUSY;
               end
            end
            DIVZERO: stateNext_s = DONE;
            DONE: begin
               if (!bus.start_i) begin
                  stateNext_s = IDLE;
               end else begin
                  stateNext_s = DONE;
               end
            end
            default: stateNext_s = IDLE;
         endcase
      end
   end

   // State register and the ready flag that mirrors residency in DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         ready_r <= 1'b0;
      end else begin
         state_r <= stateNext_s;
         ready_r <= (stateNext_s == DONE);
      end
   end

   // Operand capture, iteration datapath and result register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r          <= {CNT_W{1'b0}};
         rem_r          <= {WIDTH{1'b0}};
         quo_r          <= {WIDTH{1'b0}};
         divisor_r      <= {WIDTH{1'b0}};
         dividendSign_r <= 1'b0;
         divisorSign_r  <= 1'b0;
         signed_r       <= 1'b0;
         result_r       <= {(2*WIDTH){1'b0}};
      end else if (bus.annul_i) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start_i && !divByZero_s) begin
                  cnt_r          <= {CNT_W{1'b0}};
                  rem_r          <= {WIDTH{1'b0}};
                  quo_r          <= absDividend_s;
                  divisor_r      <= absDivisor_s;
                  dividendSign_r <= bus.opNum1_i[WIDTH-1];
                  divisorSign_r  <= bus.opNum2_i[WIDTH-1];
                  signed_r       <= bus.signed_i;
               end
            end
            BUSY: begin
               rem_r <= remStep_s;
               quo_r <= quoStep_s;
               cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               if (lastStep_s) begin
                  result_r <= {remFixed_s, quoFixed_s};
               end
            end
            DIVZERO: result_r <= {(2*WIDTH){1'b0}};
            DONE:    cnt_r    <= {CNT_W{1'b0}};
            default: cnt_r    <= {CNT_W{1'b0}};
         endcase
      end
   end

   assign bus.result_o   = result_r;
   assign bus.ready_o    = ready_r;
   assign bus.stallreq_o = bus.start_i & ~ready_r & ~bus.annul_i;

endmodule

// File: tb/tb_div_seq.sv
// Directed-vector bench for div_seq: stimulus pushes expected results into a
// queue and an independent monitor compares them on each rising ready_o.
module tb_div_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   div_seq_if #(.WIDTH(32)) bus ();
   div_seq #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

   int          checks = 0;
   int          errors = 0;
   logic [63:0] expQ[$];
   string       nameQ[$];
   logic [63:0] lastRes = 64'h0;
   logic        monPrev = 1'b0;
   logic [63:0] monExp;
   string       monName;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h, required 0x%h", nm, act, exp);
      end
   endtask

   // Monitor: compare against the scoreboard whenever ready_o rises.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.ready_o === 1'b1 && monPrev !== 1'b1) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ready: got result 0x%h, required no response", bus.result_o);
            end else begin
               monName = nameQ.pop_front();
               monExp  = expQ.pop_front();
               check({monName, "_result"}, bus.result_o, monExp);
            end
         end
         monPrev = bus.ready_o;
      end
   end

   task automatic doDiv(input string nm, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int expLat, input logic [63:0] expRes);
      int lat;
      int stalls;
      @(negedge clk);
      expQ.push_back(expRes);
      nameQ.push_back(nm);
      bus.signed_i = sgn;
      bus.opNum1_i = a;
      bus.opNum2_i = b;
      bus.start_i  = 1'b1;
      #1;
      lat    = 0;
      stalls = 0;
      while (bus.ready_o !== 1'b1 && lat < 60) begin
         if (bus.stallreq_o === 1'b1) stalls++;
         @(posedge clk);
         #1;
         lat++;
         if (lat == 3) begin
            bus.opNum1_i = ~a;
            bus.opNum2_i = 32'h0000_0003;
            bus.signed_i = ~sgn;
         end
      end
      check({nm, "_latency"}, 64'(lat), 64'(expLat));
      check({nm, "_stall_cycles"}, 64'(stalls), 64'(expLat));
      check({nm, "_stall_drop"}, {63'h0, bus.stallreq_o}, 64'h0);
      @(posedge clk);
      #1;
      check({nm, "_done_hold"}, {63'h0, bus.ready_o}, 64'h1);
      @(negedge clk);
      bus.start_i = 1'b0;
      @(posedge clk);
      #1;
      check({nm, "_back_idle"}, {63'h0, bus.ready_o}, 64'h0);
      lastRes = expRes;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst          = 1'b0;
      bus.start_i  = 1'b0;
      bus.signed_i = 1'b0;
      bus.opNum1_i = 32'h0;
      bus.opNum2_i = 32'h0;
      bus.annul_i  = 1'b0;
      #22;
      check("reset_ready", {63'h0, bus.ready_o}, 64'h0);
      check("reset_result", bus.result_o, 64'h0);
      check("reset_stall", {63'h0, bus.stallreq_o}, 64'h0);
      @(negedge clk);
      rst = 1'b1;

      doDiv("divu_100_7",   1'b0, 32'd100,       32'd7,         33, {32'd2, 32'd14});
      doDiv("div_m7_2",     1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      doDiv("div_7_m2",     1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 33, {32'h0000_0001, 32'hFFFF_FFFD});
      doDiv("div_m100_m7",  1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, {32'hFFFF_FFFE, 32'h0000_000E});
      doDiv("div_by_zero",  1'b1, 32'd5,         32'd0,         2,  64'h0);

      // Flush in the middle of an operation.
      @(negedge clk);
      bus.signed_i = 1'b0;
      bus.opNum1_i = 32'd1000;
      bus.opNum2_i = 32'd3;
      bus.start_i  = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      bus.annul_i = 1'b1;
      #1;
      check("annul_stall", {63'h0, bus.stallreq_o}, 64'h0);
      @(posedge clk);
      #1;
      check("annul_ready", {63'h0, bus.ready_o}, 64'h0);
      check("annul_result_kept", bus.result_o, lastRes);
      @(negedge clk);
      bus.annul_i = 1'b0;
      bus.start_i = 1'b0;
      repeat (3) @(posedge clk);

      doDiv("divu_50_5",    1'b0, 32'd50,        32'd5,         33, {32'd0, 32'd10});
      doDiv("div_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0, 32'h8000_0000});
      doDiv("divu_max_1",   1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 33, {32'h0, 32'hFFFF_FFFF});
      doDiv("divu_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h8000_0000, 32'h0});

      // Asynchronous reset in the middle of an operation.
      @(negedge clk);
      bus.signed_i = 1'b0;
      bus.opNum1_i = 32'd100;
      bus.opNum2_i = 32'd7;
      bus.start_i  = 1'b1;
      repeat (8) @(posedge clk);
      #2;
      rst = 1'b0;
      bus.start_i = 1'b0;
      #1;
      check("async_rst_ready", {63'h0, bus.ready_o}, 64'h0);
      check("async_rst_result", bus.result_o, 64'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      doDiv("divu_after_rst", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(expQ.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
